// File: rtl/sort_pkg.sv
// Shared types and state encodings for the in-place bubble-sort controller.
package sort_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_READ = 2'd1;
    localparam state_t ST_CMP  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/ram_sort_ctrl.sv
// Bubble-sort sequencer for a dual-port RAM with 1-cycle registered reads.
// While idle, RAM port A is handed to the host; while sorting it owns both ports.
module ram_sort_ctrl
    import sort_pkg::*;
#(
    parameter int unsigned DWIDTH    = 16,
    parameter int unsigned AWIDTH    = 5,
    parameter int unsigned NUM_WORDS = 2**AWIDTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [AWIDTH:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic [AWIDTH-1:0] host_addr_i,
    input  logic              host_wr_en_i,
    input  logic [DWIDTH-1:0] host_wr_data_i,
    output logic [DWIDTH-1:0] host_rd_data_o,
    output logic [AWIDTH-1:0] ram_a_addr_o,
    output logic [AWIDTH-1:0] ram_b_addr_o,
    output logic              ram_a_wr_en_o,
    output logic              ram_b_wr_en_o,
    output logic [DWIDTH-1:0] ram_a_wr_data_o,
    output logic [DWIDTH-1:0] ram_b_wr_data_o,
    input  logic [DWIDTH-1:0] ram_a_rd_data_i,
    input  logic [DWIDTH-1:0] ram_b_rd_data_i
);

    localparam int unsigned LWIDTH = AWIDTH + 1;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   idx_q, idx_d;
    logic                swapped_q, swapped_d;
    logic [LWIDTH-1:0]   pass_cnt_q, pass_cnt_d;
    logic [LWIDTH-1:0]   eff_len_q, eff_len_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                swap_c;
    logic                last_pair_c;
    logic                more_pass_c;
    logic [LWIDTH-1:0]   len_clamp_c;

    assign swap_c      = ram_a_rd_data_i > ram_b_rd_data_i;
    assign len_clamp_c = (len_i > LWIDTH'(NUM_WORDS)) ? LWIDTH'(NUM_WORDS) : len_i;
    assign last_pair_c = !(LWIDTH'(idx_q) < (eff_len_q - LWIDTH'(2)));
    // Another pass only if something moved and the pass limit is not yet reached
    assign more_pass_c = (swapped_q | swap_c) &&
                         ((pass_cnt_q + LWIDTH'(1)) < (eff_len_q - LWIDTH'(1)));

    assign host_rd_data_o = ram_a_rd_data_i;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        swapped_d       = swapped_q;
        pass_cnt_d      = pass_cnt_q;
        eff_len_d       = eff_len_q;
        ram_a_addr_o    = '0;
        ram_b_addr_o    = '0;
        ram_a_wr_en_o   = 1'b0;
        ram_b_wr_en_o   = 1'b0;
        ram_a_wr_data_o = '0;
        ram_b_wr_data_o = '0;

        case (state_q)
            ST_IDLE: begin
                ram_a_addr_o    = host_addr_i;
                ram_a_wr_en_o   = host_wr_en_i;
                ram_a_wr_data_o = host_wr_data_i;
                if (start_i) begin
                    eff_len_d = len_clamp_c;
                    if (len_clamp_c < LWIDTH'(2)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d      = '0;
                        swapped_d  = 1'b0;
                        pass_cnt_d = '0;
                        state_d    = ST_READ;
                    end
                end
            end
            ST_READ: begin
                ram_a_addr_o = idx_q;
                ram_b_addr_o = idx_q + AWIDTH'(1);
                state_d      = ST_CMP;
            end
            ST_CMP: begin
                ram_a_addr_o = idx_q;
                ram_b_addr_o = idx_q + AWIDTH'(1);
                // Strict compare keeps equal elements in order
                if (swap_c) begin
                    ram_a_wr_en_o   = 1'b1;
                    ram_b_wr_en_o   = 1'b1;
                    ram_a_wr_data_o = ram_b_rd_data_i;
                    ram_b_wr_data_o = ram_a_rd_data_i;
                    swapped_d       = 1'b1;
                end
                if (!last_pair_c) begin
                    idx_d   = idx_q + AWIDTH'(1);
                    state_d = ST_READ;
                end else begin
                    pass_cnt_d = pass_cnt_q + LWIDTH'(1);
                    if (more_pass_c) begin
                        idx_d     = '0;
                        swapped_d = 1'b0;
                        state_d   = ST_READ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d == ST_READ) || (state_d == ST_CMP);
    assign done_d = (state_d == ST_DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            swapped_q  <= 1'b0;
            pass_cnt_q <= '0;
            eff_len_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            swapped_q  <= swapped_d;
            pass_cnt_q <= pass_cnt_d;
            eff_len_q  <= eff_len_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_ram_sort_ctrl.sv
// Randomized self-checking bench for ram_sort_ctrl with a behavioural dual-port RAM.
module tb_ram_sort_ctrl;

    localparam int unsigned DWIDTH    = 16;
    localparam int unsigned AWIDTH    = 5;
    localparam int unsigned NUM_WORDS = 2**AWIDTH;
    localparam int          BUDGET    = 2 * NUM_WORDS * NUM_WORDS + 20;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic [AWIDTH:0]   len_i;
    logic              busy_o;
    logic              done_o;
    logic [AWIDTH-1:0] host_addr_i;
    logic              host_wr_en_i;
    logic [DWIDTH-1:0] host_wr_data_i;
    logic [DWIDTH-1:0] host_rd_data_o;
    logic [AWIDTH-1:0] ram_a_addr_o, ram_b_addr_o;
    logic              ram_a_wr_en_o, ram_b_wr_en_o;
    logic [DWIDTH-1:0] ram_a_wr_data_o, ram_b_wr_data_o;
    logic [DWIDTH-1:0] ram_a_rd_data_i, ram_b_rd_data_i;

    logic [DWIDTH-1:0] mem     [NUM_WORDS];
    logic [DWIDTH-1:0] ref_mem [NUM_WORDS];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    ram_sort_ctrl #(
        .DWIDTH    (DWIDTH),
        .AWIDTH    (AWIDTH),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .len_i           (len_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .host_addr_i     (host_addr_i),
        .host_wr_en_i    (host_wr_en_i),
        .host_wr_data_i  (host_wr_data_i),
        .host_rd_data_o  (host_rd_data_o),
        .ram_a_addr_o    (ram_a_addr_o),
        .ram_b_addr_o    (ram_b_addr_o),
        .ram_a_wr_en_o   (ram_a_wr_en_o),
        .ram_b_wr_en_o   (ram_b_wr_en_o),
        .ram_a_wr_data_o (ram_a_wr_data_o),
        .ram_b_wr_data_o (ram_b_wr_data_o),
        .ram_a_rd_data_i (ram_a_rd_data_i),
        .ram_b_rd_data_i (ram_b_rd_data_i)
    );

    // True dual-port RAM, registered read, old data on same-edge read
    always @(posedge clk_i) begin
        if (ram_a_wr_en_o) mem[ram_a_addr_o] <= ram_a_wr_data_o;
        if (ram_b_wr_en_o) mem[ram_b_addr_o] <= ram_b_wr_data_o;
        ram_a_rd_data_i <= mem[ram_a_addr_o];
        ram_b_rd_data_i <= mem[ram_b_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Number of element pairs out of order: each costs exactly one swap
    function automatic int inversions(input int len);
        int n = 0;
        for (int i = 0; i < len; i++)
            for (int j = i + 1; j < len; j++)
                if (ref_mem[i] > ref_mem[j]) n++;
        return n;
    endfunction

    // Largest count of greater elements to the left of any element = passes that move data
    function automatic int max_left_greater(input int len);
        int m = 0;
        for (int j = 0; j < len; j++) begin
            int c = 0;
            for (int i = 0; i < j; i++)
                if (ref_mem[i] > ref_mem[j]) c++;
            if (c > m) m = c;
        end
        return m;
    endfunction

    task automatic load_mem();
        for (int a = 0; a < NUM_WORDS; a++) begin
            @(negedge clk_i);
            host_addr_i    = AWIDTH'(a);
            host_wr_en_i   = 1'b1;
            host_wr_data_i = ref_mem[a];
        end
        @(negedge clk_i);
        host_wr_en_i = 1'b0;
    endtask

    task automatic run_sort(input string tag, input int len_req, input bit disturb);
        int                L, passes, exp_busy, exp_done, exp_wr;
        int                cyc, busy_cnt, wr_cnt, done_cyc;
        logic [DWIDTH-1:0] exp_q[$];

        L = (len_req > NUM_WORDS) ? NUM_WORDS : len_req;
        if (L < 2) begin
            passes = 0; exp_busy = 0; exp_done = 1; exp_wr = 0;
        end else begin
            passes   = max_left_greater(L) + 1;
            if (passes > L - 1) passes = L - 1;
            exp_busy = passes * 2 * (L - 1);
            exp_done = exp_busy + 1;
            exp_wr   = inversions(L);
        end
        exp_q = {};
        for (int i = 0; i < L; i++) exp_q.push_back(ref_mem[i]);
        exp_q.sort();

        load_mem();
        @(negedge clk_i);
        start_i = 1'b1;
        len_i   = (AWIDTH + 1)'(len_req);
        @(negedge clk_i);
        start_i = 1'b0;
        cyc = 1; busy_cnt = 0; wr_cnt = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < BUDGET) begin
            if (busy_o) busy_cnt++;
            if (ram_a_wr_en_o) wr_cnt++;
            if (done_o) done_cyc = cyc;
            if (disturb && !done_o) begin
                start_i        = 1'b1;
                len_i          = (AWIDTH + 1)'($urandom_range(0, NUM_WORDS));
                host_addr_i    = AWIDTH'($urandom);
                host_wr_en_i   = 1'b1;
                host_wr_data_i = DWIDTH'($urandom);
            end else begin
                start_i      = 1'b0;
                host_wr_en_i = 1'b0;
            end
            @(negedge clk_i);
            cyc++;
        end
        check({tag, " done_cycle"}, done_cyc, exp_done);
        check({tag, " busy_cycles"}, busy_cnt, exp_busy);
        check({tag, " ram_writes"}, wr_cnt, exp_wr);
        check({tag, " done_pulse_width"}, {31'd0, done_o}, 0);
        check({tag, " busy_after"}, {31'd0, busy_o}, 0);
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (i < L) check($sformatf("%s mem[%0d]", tag, i), {16'd0, mem[i]}, {16'd0, exp_q[i]});
            else       check($sformatf("%s tail[%0d]", tag, i), {16'd0, mem[i]}, {16'd0, ref_mem[i]});
        end
        // Read back one element through the host port
        host_addr_i = '0;
        @(negedge clk_i);
        check({tag, " host_rd0"}, {16'd0, host_rd_data_o}, {16'd0, (L > 0) ? exp_q[0] : ref_mem[0]});
    endtask

    task automatic fill_random(input int maxval);
        for (int i = 0; i < NUM_WORDS; i++) ref_mem[i] = DWIDTH'($urandom_range(0, maxval));
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; len_i = '0;
        host_addr_i = 5'd7; host_wr_en_i = 1'b1; host_wr_data_i = 16'hBEEF;
        for (int i = 0; i < NUM_WORDS; i++) mem[i] = '0;
        #12;
        check("rst busy", {31'd0, busy_o}, 0);
        check("rst done", {31'd0, done_o}, 0);
        check("rst b_wr_en", {31'd0, ram_b_wr_en_o}, 0);
        check("rst b_addr", {27'd0, ram_b_addr_o}, 0);
        check("rst b_wr_data", {16'd0, ram_b_wr_data_o}, 0);
        check("rst a_addr passthru", {27'd0, ram_a_addr_o}, 7);
        check("rst a_wr_en passthru", {31'd0, ram_a_wr_en_o}, 1);
        check("rst a_wr_data passthru", {16'd0, ram_a_wr_data_o}, 16'hBEEF);
        host_wr_en_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        fill_random(16'hFFFF);
        ref_mem[0] = 16'd3; ref_mem[1] = 16'd1; ref_mem[2] = 16'd2;
        run_sort("s312", 3, 1'b0);

        fill_random(16'hFFFF);
        for (int i = 0; i < 8; i++) ref_mem[i] = DWIDTH'(10 * i + 1);
        run_sort("asc8", 8, 1'b0);

        fill_random(16'hFFFF);
        for (int i = 0; i < 4; i++) ref_mem[i] = DWIDTH'(4 - i);
        run_sort("rev4", 4, 1'b0);

        fill_random(16'hFFFF);
        run_sort("len0", 0, 1'b0);
        run_sort("len1", 1, 1'b0);
        run_sort("len33", NUM_WORDS + 1, 1'b0);

        fill_random(16'hFFFF);
        ref_mem[0] = 16'd2; ref_mem[1] = 16'd2; ref_mem[2] = 16'd1;
        run_sort("dup221", 3, 1'b0);

        fill_random(16'hFFFF);
        run_sort("disturb", 12, 1'b1);

        for (int r = 0; r < 6; r++) begin
            fill_random((r % 2 == 0) ? 7 : 16'hFFFF);
            run_sort($sformatf("rnd%0d", r), $urandom_range(2, NUM_WORDS), 1'b0);
        end

        // Reset in the middle of a sort
        fill_random(16'hFFFF);
        for (int i = 0; i < 8; i++) ref_mem[i] = DWIDTH'(100 - i);
        load_mem();
        @(negedge clk_i);
        start_i = 1'b1; len_i = 6'd8;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("midsort busy_before", {31'd0, busy_o}, 1);
        host_addr_i = 5'd19;
        rst_ni = 1'b0;
        #1;
        check("midrst busy", {31'd0, busy_o}, 0);
        check("midrst done", {31'd0, done_o}, 0);
        check("midrst b_wr_en", {31'd0, ram_b_wr_en_o}, 0);
        check("midrst b_addr", {27'd0, ram_b_addr_o}, 0);
        check("midrst idle passthru", {27'd0, ram_a_addr_o}, 19);
        @(negedge clk_i);
        rst_ni = 1'b1;

        fill_random(16'hFFFF);
        run_sort("after_rst", 10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
